// File: rtl/jtcps1_gfx_arb.sv
// Round-robin arbiter sharing the CPS1 32-bit GFX ROM slot between the scroll and two star fetchers.
// Star fetchers arbitrate only when JTCPS1_STARS_EN is defined; otherwise stars read as transparent.
module jtcps1_gfx_arb #(
  parameter logic [21:0] STAR_BASE = 22'h3F_C000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] scr_addr_i,
  input  logic        scr_half_i,
  input  logic        scr_cs_i,
  output logic        scr_ok_o,
  output logic [31:0] scr_data_o,
  input  logic [12:0] star0_addr_i,
  input  logic        star0_cs_i,
  output logic        star0_ok_o,
  output logic [31:0] star0_data_o,
  input  logic [12:0] star1_addr_i,
  input  logic        star1_cs_i,
  output logic        star1_ok_o,
  output logic [31:0] star1_data_o,
  output logic [21:0] rom_addr_o,
  output logic        rom_half_o,
  output logic        rom_cs_o,
  input  logic        rom_ok_i,
  input  logic [31:0] rom_data_i
);

  localparam int unsigned AW  = 22;
  localparam int unsigned DW  = 32;
  localparam int unsigned SAW = 20;
  localparam int unsigned TAW = 13;
  localparam int unsigned TW  = 8;

  localparam logic [1:0]    REQ_SCR  = 2'd0;
  localparam logic [1:0]    REQ_S0   = 2'd1;
  localparam logic [1:0]    REQ_S1   = 2'd2;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    win_q, win_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          rom_half_q, rom_half_d;
  logic          rom_cs_q, rom_cs_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          drop_q, drop_d;
  logic [SAW:0]  scr_tag_q, scr_tag_d;
  logic          scr_vld_q, scr_vld_d;
  logic [DW-1:0] scr_data_q, scr_data_d;

  logic [AW-1:0] scr_rom;
  logic          scr_hit;
  logic [2:0]    pend;
  logic [1:0]    pick;
  logic          win_match;
  logic          drop_now;

  assign scr_rom    = {2'b00, scr_addr_i};
  assign scr_hit    = scr_cs_i && scr_vld_q && ({scr_half_i, scr_addr_i} == scr_tag_q);
  assign scr_ok_o   = scr_hit;
  assign scr_data_o = scr_data_q;
  assign rom_addr_o = rom_addr_q;
  assign rom_half_o = rom_half_q;
  assign rom_cs_o   = rom_cs_q;

`ifdef JTCPS1_STARS_EN
  localparam logic [AW-1:0] STAR1_BASE = STAR_BASE + 22'd8192;

  logic [TAW-1:0] s0_tag_q, s0_tag_d, s1_tag_q, s1_tag_d;
  logic           s0_vld_q, s0_vld_d, s1_vld_q, s1_vld_d;
  logic [DW-1:0]  s0_data_q, s0_data_d, s1_data_q, s1_data_d;
  logic [AW-1:0]  s0_rom, s1_rom;
  logic           s0_hit, s1_hit;

  assign s0_rom       = STAR_BASE + {9'd0, star0_addr_i};
  assign s1_rom       = STAR1_BASE + {9'd0, star1_addr_i};
  assign s0_hit       = star0_cs_i && s0_vld_q && (star0_addr_i == s0_tag_q);
  assign s1_hit       = star1_cs_i && s1_vld_q && (star1_addr_i == s1_tag_q);
  assign star0_ok_o   = s0_hit;
  assign star1_ok_o   = s1_hit;
  assign star0_data_o = s0_data_q;
  assign star1_data_o = s1_data_q;
  assign pend         = {star1_cs_i & ~s1_hit, star0_cs_i & ~s0_hit, scr_cs_i & ~scr_hit};
`else
  logic unused_star;

  assign star0_ok_o   = star0_cs_i;
  assign star1_ok_o   = star1_cs_i;
  assign star0_data_o = 32'hFFFF_FFFF;
  assign star1_data_o = 32'hFFFF_FFFF;
  assign pend         = {2'b00, scr_cs_i & ~scr_hit};
  assign unused_star  = &{1'b0, star0_addr_i, star1_addr_i, STAR_BASE};
`endif

  // First pending requester at or after the round-robin pointer
  always_comb begin
    case (ptr_q)
      REQ_S0:  pick = pend[1] ? REQ_S0  : (pend[2] ? REQ_S1  : REQ_SCR);
      REQ_S1:  pick = pend[2] ? REQ_S1  : (pend[0] ? REQ_SCR : REQ_S0);
      default: pick = pend[0] ? REQ_SCR : (pend[1] ? REQ_S0  : REQ_S1);
    endcase
  end

  // Winner still presents the address that is on the ROM bus
  always_comb begin
    win_match = scr_cs_i && (scr_rom == rom_addr_q) && (scr_half_i == rom_half_q);
`ifdef JTCPS1_STARS_EN
    if (win_q == REQ_S0)      win_match = star0_cs_i && (s0_rom == rom_addr_q);
    else if (win_q == REQ_S1) win_match = star1_cs_i && (s1_rom == rom_addr_q);
`endif
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    rom_addr_d = rom_addr_q;
    rom_half_d = rom_half_q;
    rom_cs_d   = rom_cs_q;
    tmr_d      = tmr_q;
    drop_d     = drop_q;
    scr_tag_d  = scr_tag_q;
    scr_vld_d  = scr_vld_q;
    scr_data_d = scr_data_q;
`ifdef JTCPS1_STARS_EN
    s0_tag_d   = s0_tag_q;
    s0_vld_d   = s0_vld_q;
    s0_data_d  = s0_data_q;
    s1_tag_d   = s1_tag_q;
    s1_vld_d   = s1_vld_q;
    s1_data_d  = s1_data_q;
`endif
    drop_now   = drop_q | ~win_match;

    case (state_q)
      ST_WAIT: begin
        drop_d = drop_now;
        if (rom_ok_i || (tmr_q == TMO_LAST)) begin
          state_d  = ST_GAP;
          rom_cs_d = 1'b0;
`ifdef JTCPS1_STARS_EN
          ptr_d    = (win_q == REQ_S1) ? REQ_SCR : win_q + 2'd1;
`endif
          // A winner that moved away while waiting gets nothing; it re-arbitrates
          if (rom_ok_i && !drop_now) begin
            if (win_q == REQ_SCR) begin
              scr_tag_d  = {scr_half_i, scr_addr_i};
              scr_vld_d  = 1'b1;
              scr_data_d = rom_data_i;
            end
`ifdef JTCPS1_STARS_EN
            else if (win_q == REQ_S0) begin
              s0_tag_d  = star0_addr_i;
              s0_vld_d  = 1'b1;
              s0_data_d = rom_data_i;
            end else begin
              s1_tag_d  = star1_addr_i;
              s1_vld_d  = 1'b1;
              s1_data_d = rom_data_i;
            end
`endif
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      // GAP keeps rom_cs low for this cycle but may already launch the next grant
      default: begin
        state_d  = ST_IDLE;
        rom_cs_d = 1'b0;
        if (|pend) begin
          state_d    = ST_WAIT;
          rom_cs_d   = 1'b1;
          tmr_d      = '0;
          drop_d     = 1'b0;
          win_d      = pick;
          rom_addr_d = scr_rom;
          rom_half_d = scr_half_i;
`ifdef JTCPS1_STARS_EN
          if (pick == REQ_S0) begin
            rom_addr_d = s0_rom;
            rom_half_d = 1'b0;
          end else if (pick == REQ_S1) begin
            rom_addr_d = s1_rom;
            rom_half_d = 1'b0;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= REQ_SCR;
      win_q      <= REQ_SCR;
      rom_addr_q <= '0;
      rom_half_q <= 1'b0;
      rom_cs_q   <= 1'b0;
      tmr_q      <= '0;
      drop_q     <= 1'b0;
      scr_tag_q  <= '0;
      scr_vld_q  <= 1'b0;
      scr_data_q <= '0;
`ifdef JTCPS1_STARS_EN
      s0_tag_q   <= '0;
      s0_vld_q   <= 1'b0;
      s0_data_q  <= '0;
      s1_tag_q   <= '0;
      s1_vld_q   <= 1'b0;
      s1_data_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      rom_addr_q <= rom_addr_d;
      rom_half_q <= rom_half_d;
      rom_cs_q   <= rom_cs_d;
      tmr_q      <= tmr_d;
      drop_q     <= drop_d;
      scr_tag_q  <= scr_tag_d;
      scr_vld_q  <= scr_vld_d;
      scr_data_q <= scr_data_d;
`ifdef JTCPS1_STARS_EN
      s0_tag_q   <= s0_tag_d;
      s0_vld_q   <= s0_vld_d;
      s0_data_q  <= s0_data_d;
      s1_tag_q   <= s1_tag_d;
      s1_vld_q   <= s1_vld_d;
      s1_data_q  <= s1_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_jtcps1_gfx_arb.sv
// Directed bench for jtcps1_gfx_arb with a small SDRAM slot model (fixed latency, address-derived data).
module tb_jtcps1_gfx_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] scr_addr;
  logic        scr_half, scr_cs, scr_ok;
  logic [31:0] scr_data;
  logic [12:0] star0_addr, star1_addr;
  logic        star0_cs, star0_ok, star1_cs, star1_ok;
  logic [31:0] star0_data, star1_data;
  logic [21:0] rom_addr;
  logic        rom_half, rom_cs;
  logic        rom_ok = 1'b0;
  logic [31:0] rom_data = 32'd0;

  int   n_cmp = 0;
  int   n_err = 0;
  logic sd_en;
  int   sd_lat;
  int   sd_cnt = 0;
  logic sd_done = 1'b0;

  jtcps1_gfx_arb dut (
    .clk(clk), .rst(rst),
    .scr_addr_i(scr_addr), .scr_half_i(scr_half), .scr_cs_i(scr_cs),
    .scr_ok_o(scr_ok), .scr_data_o(scr_data),
    .star0_addr_i(star0_addr), .star0_cs_i(star0_cs),
    .star0_ok_o(star0_ok), .star0_data_o(star0_data),
    .star1_addr_i(star1_addr), .star1_cs_i(star1_cs),
    .star1_ok_o(star1_ok), .star1_data_o(star1_data),
    .rom_addr_o(rom_addr), .rom_half_o(rom_half), .rom_cs_o(rom_cs),
    .rom_ok_i(rom_ok), .rom_data_i(rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sdram_word(input logic [21:0] a);
    return (a == 22'h000123) ? 32'hDEADBEEF : {10'h155, a};
  endfunction

  // SDRAM slot: one rom_ok pulse sd_lat+1 cycles after rom_cs rises
  always @(posedge clk) begin
    #1;
    rom_ok = 1'b0;
    if (rst || !rom_cs) begin
      sd_cnt  = 0;
      sd_done = 1'b0;
    end else if (sd_en && !sd_done) begin
      if (sd_cnt >= sd_lat) begin
        rom_ok   = 1'b1;
        rom_data = sdram_word(rom_addr);
        sd_done  = 1'b1;
      end else begin
        sd_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    scr_addr = '0; scr_half = 1'b0; scr_cs = 1'b0;
    star0_addr = '0; star0_cs = 1'b0; star1_addr = '0; star1_cs = 1'b0;
    sd_en = 1'b1; sd_lat = 5;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    scr_addr = '0; scr_half = 1'b0; scr_cs = 1'b0;
    star0_addr = '0; star0_cs = 1'b0; star1_addr = '0; star1_cs = 1'b0;
    sd_en = 1'b0; sd_lat = 5;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL reset_rom_cs: got %b want 0", rom_cs); end
    n_cmp++; if (rom_addr !== 22'h0) begin n_err++; $display("FAIL reset_rom_addr: got %h want 000000", rom_addr); end
    n_cmp++; if (rom_half !== 1'b0) begin n_err++; $display("FAIL reset_rom_half: got %b want 0", rom_half); end
    n_cmp++; if (scr_ok !== 1'b0) begin n_err++; $display("FAIL reset_scr_ok: got %b want 0", scr_ok); end
    n_cmp++; if (scr_data !== 32'h0) begin n_err++; $display("FAIL reset_scr_data: got %h want 0", scr_data); end
    n_cmp++; if (star0_ok !== 1'b0) begin n_err++; $display("FAIL reset_star0_ok: got %b want 0", star0_ok); end
    n_cmp++; if (star1_ok !== 1'b0) begin n_err++; $display("FAIL reset_star1_ok: got %b want 0", star1_ok); end
`ifdef JTCPS1_STARS_EN
    n_cmp++; if (star0_data !== 32'h0) begin n_err++; $display("FAIL reset_star0_data: got %h want 0", star0_data); end
`else
    n_cmp++; if (star0_data !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_star0_data: got %h want ffffffff", star0_data); end
`endif
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    sd_en = 1'b0;
    scr_addr = 20'h00123; scr_cs = 1'b1;
    tick();
    n_cmp++; if (rom_cs !== 1'b1) begin n_err++; $display("FAIL midwait_grant_cs: got %b want 1", rom_cs); end
    n_cmp++; if (rom_addr !== 22'h000123) begin n_err++; $display("FAIL midwait_grant_addr: got %h want 000123", rom_addr); end
    tick(); tick();
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL midwait_rst_cs: got %b want 0", rom_cs); end
    n_cmp++; if (scr_ok !== 1'b0) begin n_err++; $display("FAIL midwait_rst_ok: got %b want 0", scr_ok); end
    n_cmp++; if (scr_data !== 32'h0) begin n_err++; $display("FAIL midwait_rst_data: got %h want 0", scr_data); end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (rom_cs !== 1'b1) begin n_err++; $display("FAIL midwait_rereq_cs: got %b want 1", rom_cs); end
    n_cmp++; if (rom_addr !== 22'h000123) begin n_err++; $display("FAIL midwait_rereq_addr: got %h want 000123", rom_addr); end
    n_cmp++; if (scr_ok !== 1'b0) begin n_err++; $display("FAIL midwait_rereq_ok: got %b want 0", scr_ok); end
  endtask

  task automatic test_single_fetch();
    int cyc;
    logic seen;
    logic [21:0] seen_addr;
    apply_reset();
    scr_addr = 20'h00123; scr_half = 1'b0; scr_cs = 1'b1;
    cyc = 0; seen = 1'b0; seen_addr = '0;
    while (!scr_ok && cyc < 50) begin
      tick(); cyc++;
      if (rom_cs && !seen) begin seen = 1'b1; seen_addr = rom_addr; end
    end
    n_cmp++; if (seen_addr !== 22'h000123) begin n_err++; $display("FAIL single_rom_addr: got %h want 000123", seen_addr); end
    n_cmp++; if (cyc != 7) begin n_err++; $display("FAIL single_latency: got %0d want 7", cyc); end
    n_cmp++; if (scr_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data: got %h want deadbeef", scr_data); end
    n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL single_gap_cs: got %b want 0", rom_cs); end
    tick();
    n_cmp++; if (rom_cs !== 1'b0 || scr_ok !== 1'b1) begin n_err++; $display("FAIL single_hold: got cs=%b ok=%b want cs=0 ok=1", rom_cs, scr_ok); end
    scr_cs = 1'b0; #1;
    n_cmp++; if (scr_ok !== 1'b0) begin n_err++; $display("FAIL single_cs_drop: got %b want 0", scr_ok); end
    scr_cs = 1'b1; #1;
    n_cmp++; if (scr_ok !== 1'b1) begin n_err++; $display("FAIL single_cache_hit: got %b want 1", scr_ok); end
    tick();
    n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL single_hit_no_cs: got %b want 0", rom_cs); end
    scr_half = 1'b1; #1;
    n_cmp++; if (scr_ok !== 1'b0) begin n_err++; $display("FAIL half_miss: got %b want 0", scr_ok); end
    tick();
    n_cmp++; if (rom_cs !== 1'b1 || rom_half !== 1'b1) begin n_err++; $display("FAIL half_req: got cs=%b half=%b want 1 1", rom_cs, rom_half); end
    cyc = 0;
    while (!scr_ok && cyc < 50) begin tick(); cyc++; end
    n_cmp++; if (scr_ok !== 1'b1 || scr_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL half_fetch: got ok=%b data=%h want 1 deadbeef", scr_ok, scr_data); end
    scr_half = 1'b0; #1;
    n_cmp++; if (scr_ok !== 1'b0) begin n_err++; $display("FAIL half_cached: got %b want 0", scr_ok); end
    scr_cs = 1'b0;
  endtask

  task automatic test_addr_change();
    int cyc, rises;
    logic prev;
    logic [21:0] rise_addr;
    apply_reset();
    scr_addr = 20'h00200; scr_cs = 1'b1;
    tick(); tick();
    n_cmp++; if (rom_cs !== 1'b1 || rom_addr !== 22'h000200) begin n_err++; $display("FAIL chg_first_req: got cs=%b addr=%h want 1 000200", rom_cs, rom_addr); end
    scr_addr = 20'h00201; #1;
    n_cmp++; if (scr_ok !== 1'b0) begin n_err++; $display("FAIL chg_ok_low: got %b want 0", scr_ok); end
    cyc = 0; rises = 0; prev = 1'b1; rise_addr = '0;
    while (!scr_ok && cyc < 60) begin
      tick(); cyc++;
      if (rom_cs && !prev) begin rises++; rise_addr = rom_addr; end
      prev = rom_cs;
    end
    n_cmp++; if (rises != 1 || rise_addr !== 22'h000201) begin n_err++; $display("FAIL chg_refetch: got rises=%0d addr=%h want 1 000201", rises, rise_addr); end
    n_cmp++; if (scr_ok !== 1'b1 || scr_data !== sdram_word(22'h000201)) begin n_err++; $display("FAIL chg_data: got ok=%b data=%h want 1 %h", scr_ok, scr_data, sdram_word(22'h000201)); end
    // address moves on the very cycle rom_ok is presented
    scr_addr = 20'h00300;
    repeat (6) tick();
    scr_addr = 20'h00301; #1;
    n_cmp++; if (scr_ok !== 1'b0) begin n_err++; $display("FAIL sim_ok_low: got %b want 0", scr_ok); end
    tick();
    n_cmp++; if (rom_cs !== 1'b0 || scr_ok !== 1'b0) begin n_err++; $display("FAIL sim_discard: got cs=%b ok=%b want 0 0", rom_cs, scr_ok); end
    cyc = 0;
    while (!scr_ok && cyc < 60) begin tick(); cyc++; end
    n_cmp++; if (scr_ok !== 1'b1 || scr_data !== sdram_word(22'h000301)) begin n_err++; $display("FAIL sim_data: got ok=%b data=%h want 1 %h", scr_ok, scr_data, sdram_word(22'h000301)); end
    scr_addr = 20'h00300; #1;
    n_cmp++; if (scr_ok !== 1'b0) begin n_err++; $display("FAIL sim_stale: got %b want 0", scr_ok); end
    scr_cs = 1'b0;
  endtask

  task automatic test_timeout();
    int cyc, high;
    logic started;
    apply_reset();
    sd_en = 1'b0;
    scr_addr = 20'h00400; scr_cs = 1'b1;
    cyc = 0; high = 0; started = 1'b0;
    while (cyc < 400) begin
      tick(); cyc++;
      if (rom_cs) begin high++; started = 1'b1; end
      else if (started) break;
    end
    n_cmp++; if (high != 255) begin n_err++; $display("FAIL timeout_len: got %0d want 255", high); end
    n_cmp++; if (rom_cs !== 1'b0 || scr_ok !== 1'b0) begin n_err++; $display("FAIL timeout_drop: got cs=%b ok=%b want 0 0", rom_cs, scr_ok); end
    tick();
    n_cmp++; if (rom_cs !== 1'b1 || rom_addr !== 22'h000400) begin n_err++; $display("FAIL timeout_regrant: got cs=%b addr=%h want 1 000400", rom_cs, rom_addr); end
    scr_cs = 1'b0;
  endtask

`ifdef JTCPS1_STARS_EN
  task automatic test_star_offset();
    int cyc;
    apply_reset();
    scr_half = 1'b1;
    star1_addr = 13'h0010; star1_cs = 1'b1;
    tick();
    n_cmp++; if (rom_cs !== 1'b1 || rom_addr !== 22'h3FE010) begin n_err++; $display("FAIL star1_addr: got cs=%b addr=%h want 1 3fe010", rom_cs, rom_addr); end
    n_cmp++; if (rom_half !== 1'b0) begin n_err++; $display("FAIL star1_half: got %b want 0", rom_half); end
    cyc = 0;
    while (!star1_ok && cyc < 50) begin tick(); cyc++; end
    n_cmp++; if (star1_ok !== 1'b1 || star1_data !== sdram_word(22'h3FE010)) begin n_err++; $display("FAIL star1_data: got ok=%b data=%h want 1 %h", star1_ok, star1_data, sdram_word(22'h3FE010)); end
    star1_cs = 1'b0;
  endtask

  task automatic test_round_robin();
    int cyc, n, low;
    logic prev;
    logic [21:0] addrs [3];
    int gaps [3];
    apply_reset();
    scr_addr = 20'h00010; scr_cs = 1'b1;
    star0_addr = 13'h0020; star0_cs = 1'b1;
    star1_addr = 13'h0010; star1_cs = 1'b1;
    for (int i = 0; i < 3; i++) begin addrs[i] = '0; gaps[i] = 0; end
    cyc = 0; n = 0; low = 0; prev = 1'b0;
    while (!(scr_ok && star0_ok && star1_ok) && cyc < 100) begin
      tick(); cyc++;
      if (rom_cs && !prev) begin
        if (n < 3) begin addrs[n] = rom_addr; gaps[n] = low; end
        n++; low = 0;
      end else if (!rom_cs) begin
        low++;
      end
      prev = rom_cs;
    end
    n_cmp++; if (n != 3) begin n_err++; $display("FAIL rr_grants: got %0d want 3", n); end
    n_cmp++; if (addrs[0] !== 22'h000010 || addrs[1] !== 22'h3FC020 || addrs[2] !== 22'h3FE010) begin n_err++; $display("FAIL rr_order: got %h %h %h want 000010 3fc020 3fe010", addrs[0], addrs[1], addrs[2]); end
    n_cmp++; if (gaps[1] != 1 || gaps[2] != 1) begin n_err++; $display("FAIL rr_gap: got %0d %0d want 1 1", gaps[1], gaps[2]); end
    n_cmp++; if (star0_data !== sdram_word(22'h3FC020)) begin n_err++; $display("FAIL rr_star0_data: got %h want %h", star0_data, sdram_word(22'h3FC020)); end
    scr_cs = 1'b0; star0_cs = 1'b0; star1_cs = 1'b0;
  endtask
`else
  task automatic test_stars_disabled();
    apply_reset();
    star0_addr = 13'h0005; star0_cs = 1'b1;
    star1_addr = 13'h0010; star1_cs = 1'b1;
    #1;
    n_cmp++; if (star0_ok !== 1'b1 || star0_data !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL nostar0: got ok=%b data=%h want 1 ffffffff", star0_ok, star0_data); end
    n_cmp++; if (star1_ok !== 1'b1 || star1_data !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL nostar1: got ok=%b data=%h want 1 ffffffff", star1_ok, star1_data); end
    tick(); tick();
    n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL nostar_no_req: got %b want 0", rom_cs); end
    star0_cs = 1'b0; #1;
    n_cmp++; if (star0_ok !== 1'b0 || star1_ok !== 1'b1) begin n_err++; $display("FAIL nostar_follow: got %b %b want 0 1", star0_ok, star1_ok); end
    star1_cs = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_wait();
    test_single_fetch();
    test_addr_change();
    test_timeout();
`ifdef JTCPS1_STARS_EN
    test_star_offset();
    test_round_robin();
`else
    test_stars_disabled();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
